hub75_scan_ctrl: RTL and testbench

Sequencer for the HUB75 LED panel datapath. It drives the column shift, latch, output-enable and row-address timing, and applies binary-coded-modulation (BCM) bit-plane weighting. It also generates the pixel address and bit-plane index used by the pixel source and RGB mux. It sits between the top-level panel wrapper and the pixel generator, and it owns the internal pixel-rate tick.

---
 rtl/hub75_scan_ctrl_pkg.sv | 20 ++
 rtl/hub75_scan_ctrl_if.sv | 32 +++
 rtl/hub75_tick_div.sv | 27 ++
 rtl/hub75_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_scan_ctrl_pkg.sv
// Shared types and width helpers for the HUB75 scan controller.
// Widths depend on module parameters, so they are derived with width_of() at each use site.
package hub75_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StBlank,
    StLatch,
    StShow,
    StNext
  } state_e;

  // log2 that never collapses to a zero-width vector
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Scan-controller bundle: enable in, panel timing and pixel addressing out.
interface hub75_scan_ctrl_if
  import hub75_scan_ctrl_pkg::*;
#(
  parameter int unsigned COLS = 64,
  parameter int unsigned ROWS = 32,
  parameter int unsigned BITS = 4
);
  localparam int unsigned ROW_W   = width_of(ROWS);
  localparam int unsigned COL_W   = width_of(COLS);
  localparam int unsigned PLANE_W = width_of(BITS);

  logic               en;
  logic [ROW_W-1:0]   pix_row;
  logic [COL_W-1:0]   pix_col;
  logic [PLANE_W-1:0] plane;
  logic               lp_clk;
  logic               latch;
  logic               noe;
  logic [ROW_W-1:0]   row_addr;
  logic               frame_done;

  modport master (
    input  en,
    output pix_row, pix_col, plane, lp_clk, latch, noe, row_addr, frame_done
  );

  modport slave (
    output en,
    input  pix_row, pix_col, plane, lp_clk, latch, noe, row_addr, frame_done
  );
endinterface

// File: rtl/hub75_tick_div.sv
// Pixel-rate tick: one-clk pulse every CLK_DIV clocks.
module hub75_tick_div
  import hub75_scan_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 3
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned      CNT_W = width_of(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: column shift, blank/latch, BCM-weighted show time, row/plane stepping.
// Outputs are registered copies of the next state so they change together with the FSM.
module hub75_scan_ctrl
  import hub75_scan_ctrl_pkg::*;
#(
  parameter int unsigned COLS       = 64,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned BITS       = 4,
  parameter int unsigned BASE_DELAY = 20,
  parameter int unsigned CLK_DIV    = 3
) (
  input logic              clk,
  input logic              rst,
  hub75_scan_ctrl_if.master bus
);
  localparam int unsigned ROW_W   = width_of(ROWS);
  localparam int unsigned COL_W   = width_of(COLS);
  localparam int unsigned PLANE_W = width_of(BITS);
  localparam int unsigned DLY_W   = width_of((BASE_DELAY << (BITS - 1)) + 1);

  logic tick;

  hub75_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic [ROW_W-1:0]   row_addr_q, row_addr_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic               lp_clk_q, latch_q, noe_q, frame_done_q, frame_done_d;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    plane_d      = plane_q;
    row_addr_d   = row_addr_q;
    dly_d        = dly_q;
    frame_done_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (bus.en) state_d = StShiftLo;
        end
        StShiftLo: state_d = StShiftHi;
        StShiftHi: begin
          if (col_q == COL_W'(COLS - 1)) begin
            col_d   = '0;
            state_d = StBlank;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = StShiftLo;
          end
        end
        StBlank: begin
          row_addr_d = row_q;
          state_d    = StLatch;
        end
        StLatch: begin
          // Preload so SHOW lasts exactly BASE_DELAY<<plane ticks
          dly_d   = (DLY_W'(BASE_DELAY) << plane_q) - DLY_W'(1);
          state_d = StShow;
        end
        StShow: begin
          if (dly_q == '0) state_d = StNext;
          else             dly_d   = dly_q - DLY_W'(1);
        end
        StNext: begin
          if (plane_q == PLANE_W'(BITS - 1)) begin
            plane_d = '0;
            if (row_q == ROW_W'(ROWS - 1)) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            plane_d = plane_q + PLANE_W'(1);
          end
          state_d = bus.en ? StShiftLo : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      row_addr_q   <= '0;
      dly_q        <= '0;
      lp_clk_q     <= 1'b0;
      latch_q      <= 1'b0;
      noe_q        <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      plane_q      <= plane_d;
      row_addr_q   <= row_addr_d;
      dly_q        <= dly_d;
      lp_clk_q     <= (state_d == StShiftHi);
      latch_q      <= (state_d == StLatch);
      noe_q        <= (state_d != StShow);
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pix_row    = row_q;
  assign bus.pix_col    = col_q;
  assign bus.plane      = plane_q;
  assign bus.lp_clk     = lp_clk_q;
  assign bus.latch      = latch_q;
  assign bus.noe        = noe_q;
  assign bus.row_addr   = row_addr_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench: clock-by-clock trace of the first row, then frame, reset, enable and BCM corners.
module tb_hub75_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hub75_scan_ctrl_if #(.COLS(4), .ROWS(2), .BITS(2)) bus_a ();
  hub75_scan_ctrl_if #(.COLS(4), .ROWS(2), .BITS(2)) bus_b ();
  hub75_scan_ctrl_if #(.COLS(4), .ROWS(2), .BITS(4)) bus_c ();

  hub75_scan_ctrl #(
    .COLS(4), .ROWS(2), .BITS(2), .BASE_DELAY(2), .CLK_DIV(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  hub75_scan_ctrl #(
    .COLS(4), .ROWS(2), .BITS(2), .BASE_DELAY(2), .CLK_DIV(3)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  hub75_scan_ctrl #(
    .COLS(4), .ROWS(2), .BITS(4), .BASE_DELAY(20), .CLK_DIV(1)
  ) u_dut_c (
    .clk(clk), .rst(rst), .bus(bus_c)
  );

  typedef struct packed {
    logic       lp;
    logic       la;
    logic       noe;
    logic [1:0] col;
    logic       row;
    logic       pl;
    logic       ra;
    logic       fd;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t obs_a();
    return {bus_a.lp_clk, bus_a.latch, bus_a.noe, bus_a.pix_col, bus_a.pix_row, bus_a.plane,
            bus_a.row_addr, bus_a.frame_done};
  endfunction

  function automatic obs_t mk(input logic lp, input logic la, input logic noe,
                              input logic [1:0] col, input logic pl);
    return {lp, la, noe, col, 1'b0, pl, 1'b0, 1'b0};
  endfunction

  // Panel safety: latch only while dark, shift clock low while lit
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_a", {bus_a.latch & ~bus_a.noe, ~bus_a.noe & bus_a.lp_clk}, 0);
      check("inv_b", {bus_b.latch & ~bus_b.noe, ~bus_b.noe & bus_b.lp_clk}, 0);
      check("inv_c", {bus_c.latch & ~bus_c.noe, ~bus_c.noe & bus_c.lp_clk}, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    obs_t vec[14];
    int   runs[$];
    int   fd_times[$];
    int   tog[$];
    int   low, lat, rises, la_cnt, lat_len;
    bit   found, saw_ra1, prev_lp, done;

    // Expected outputs after each clock edge of the first row/plane with en held high
    vec[0]  = mk(0, 0, 1, 0, 0);
    vec[1]  = mk(1, 0, 1, 0, 0);
    vec[2]  = mk(0, 0, 1, 1, 0);
    vec[3]  = mk(1, 0, 1, 1, 0);
    vec[4]  = mk(0, 0, 1, 2, 0);
    vec[5]  = mk(1, 0, 1, 2, 0);
    vec[6]  = mk(0, 0, 1, 3, 0);
    vec[7]  = mk(1, 0, 1, 3, 0);
    vec[8]  = mk(0, 0, 1, 0, 0);
    vec[9]  = mk(0, 1, 1, 0, 0);
    vec[10] = mk(0, 0, 0, 0, 0);
    vec[11] = mk(0, 0, 0, 0, 0);
    vec[12] = mk(0, 0, 1, 0, 0);
    vec[13] = mk(0, 0, 1, 0, 1);

    bus_a.en = 1'b0;
    bus_b.en = 1'b0;
    bus_c.en = 1'b0;
    repeat (3) step();
    check("reset_a", obs_a(), mk(0, 0, 1, 0, 0));
    check("reset_b_noe", bus_b.noe, 1);
    check("reset_c_noe", bus_c.noe, 1);
    rst = 1'b0;
    bus_a.en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step();
      check($sformatf("trace_e%0d", i + 1), obs_a(), vec[i]);
    end

    // Continue through two frames, collecting SHOW lengths and frame_done times
    low = 0;
    saw_ra1 = 1'b0;
    for (int c = 15; c <= 120; c++) begin
      step();
      if (!bus_a.noe) low++;
      else if (low != 0) begin
        runs.push_back(low);
        low = 0;
      end
      if (bus_a.row_addr == 1'b1) saw_ra1 = 1'b1;
      if (bus_a.frame_done) begin
        fd_times.push_back(c);
        check("fd_row_plane_zero", {bus_a.pix_row, bus_a.plane}, 0);
      end
    end
    check("show_plane1_len", runs.size() > 0 ? runs[0] : -1, 4);
    check("show_row1_plane0_len", runs.size() > 1 ? runs[1] : -1, 2);
    check("show_row1_plane1_len", runs.size() > 2 ? runs[2] : -1, 4);
    check("row_addr_reached_1", saw_ra1, 1);
    check("fd_pulse_count", fd_times.size(), 2);
    check("fd_first_edge", fd_times.size() > 0 ? fd_times[0] : -1, 57);
    check("frame_period", fd_times.size() > 1 ? fd_times[1] - fd_times[0] : -1, 56);

    // Reset held 3 clks in the middle of SHOW
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (!bus_a.noe) found = 1'b1;
      else step();
    end
    check("wait_show", found, 1);
    rst = 1'b1;
    step();
    check("reset_mid_show", obs_a(), mk(0, 0, 1, 0, 0));
    step();
    step();
    bus_a.en = 1'b0;
    rst = 1'b0;
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus_a.lp_clk || !bus_a.noe) rises++;
    end
    check("idle_after_reset", rises, 0);
    check("idle_after_reset_obs", obs_a(), mk(0, 0, 1, 0, 0));

    // en dropped at pix_col 1: row completes, then idle with plane advanced
    bus_a.en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus_a.pix_col == 2'd1) found = 1'b1;
    end
    check("wait_col1", found, 1);
    bus_a.en = 1'b0;
    prev_lp = bus_a.lp_clk;
    rises = 0;
    la_cnt = 0;
    low = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus_a.lp_clk && !prev_lp) rises++;
      prev_lp = bus_a.lp_clk;
      if (bus_a.latch) la_cnt++;
      if (!bus_a.noe) low++;
    end
    check("drop_remaining_rises", rises, 3);
    check("drop_latch_clks", la_cnt, 1);
    check("drop_show_clks", low, 2);
    check("drop_idle_obs", obs_a(), mk(0, 0, 1, 0, 1));
    bus_a.en = 1'b1;
    step();
    check("resume_shift_lo", obs_a(), mk(0, 0, 1, 0, 1));
    step();
    check("resume_shift_hi", obs_a(), mk(1, 0, 1, 0, 1));
    bus_a.en = 1'b0;

    // Divider: every lp_clk edge 3 clks apart, latch 3 clks, plane-0 SHOW 6 clks
    bus_b.en = 1'b1;
    prev_lp = bus_b.lp_clk;
    low = 0;
    lat_len = 0;
    done = 1'b0;
    for (int c = 0; c < 150 && !done; c++) begin
      step();
      if (bus_b.lp_clk != prev_lp && tog.size() < 8) tog.push_back(c);
      prev_lp = bus_b.lp_clk;
      if (bus_b.latch) lat_len++;
      if (!bus_b.noe) low++;
      else if (low != 0) done = 1'b1;
    end
    check("div_toggle_count", tog.size(), 8);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("div_spacing_%0d", i), i < tog.size() ? tog[i] - tog[i-1] : -1, 3);
    end
    check("div_latch_len", lat_len, 3);
    check("div_show_len", low, 6);
    bus_b.en = 1'b0;

    // BCM weighting with BASE_DELAY 20 over four planes
    bus_c.en = 1'b1;
    runs.delete();
    low = 0;
    for (int c = 0; c < 1200 && runs.size() < 4; c++) begin
      step();
      if (!bus_c.noe) low++;
      else if (low != 0) begin
        runs.push_back(low);
        low = 0;
      end
    end
    check("bcm_runs_seen", runs.size(), 4);
    for (int p = 0; p < 4; p++) begin
      lat = 20 << p;
      check($sformatf("bcm_plane%0d", p), p < runs.size() ? runs[p] : -1, lat);
    end
    bus_c.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
